// File: rtl/systolic_ws_tile.sv
// Weight-stationary ROWS x COLS systolic tile: weights are loaded row by row, then
// activation vectors stream through skew -> PE array -> deskew with a fixed ROWS+COLS latency.
module systolic_ws_tile #(
    parameter int ROWS             = 32,
    parameter int COLS             = 32,
    parameter int DATAWIDTH        = 8,
    parameter int DATAWIDTH_output = 32
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               wt_valid,
    output logic                               wt_ready,
    input  logic [COLS*DATAWIDTH-1:0]          wt_row,
    input  logic                               a_valid,
    output logic                               a_ready,
    input  logic                               a_last,
    input  logic [ROWS*DATAWIDTH-1:0]          a_vec,
    input  logic                               acc_en,
    input  logic [COLS*DATAWIDTH_output-1:0]   psum_in,
    output logic                               c_valid,
    output logic [COLS*DATAWIDTH_output-1:0]   c_vec,
    output logic                               busy
);

    localparam int LAT  = ROWS + COLS;
    localparam int RIW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNTW = $clog2(LAT + 1);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t                              state, state_nxt;
    logic [RIW-1:0]                      row_idx;
    logic [CNTW-1:0]                     drain_cnt;
    logic                                wt_fire, a_fire, row_last;
    logic signed [DATAWIDTH-1:0]         w      [ROWS][COLS];
    logic signed [DATAWIDTH-1:0]         a_left [ROWS][COLS];
    logic signed [DATAWIDTH_output-1:0]  ps_up  [ROWS][COLS];
    logic signed [DATAWIDTH-1:0]         a_pe   [ROWS][COLS];
    logic signed [DATAWIDTH_output-1:0]  ps_pe  [ROWS][COLS];
    logic signed [DATAWIDTH-1:0]         a_edge [ROWS];
    logic signed [DATAWIDTH_output-1:0]  seed_edge [COLS];
    logic signed [DATAWIDTH_output-1:0]  dsk_out   [COLS];
    logic [LAT-1:0]                      vld_p;

    function automatic logic signed [DATAWIDTH_output-1:0] mac(
        input logic signed [DATAWIDTH_output-1:0] acc,
        input logic signed [DATAWIDTH-1:0]        a,
        input logic signed [DATAWIDTH-1:0]        b
    );
        logic signed [2*DATAWIDTH-1:0] prod;
        prod = (2*DATAWIDTH)'(a) * (2*DATAWIDTH)'(b);
        return acc + DATAWIDTH_output'(prod);
    endfunction

    assign wt_fire  = wt_valid && wt_ready;
    assign a_fire   = a_valid && a_ready;
    assign row_last = (row_idx == RIW'(ROWS - 1));

    always_comb begin
        state_nxt = state;
        wt_ready  = 1'b0;
        a_ready   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                wt_ready = rst_n;
                if (wt_fire) state_nxt = row_last ? COMPUTE : LOAD;
            end
            LOAD: begin
                wt_ready = rst_n;
                if (wt_fire && row_last) state_nxt = COMPUTE;
            end
            COMPUTE: begin
                a_ready = rst_n;
                if (a_fire && a_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == CNTW'(LAT)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_idx   <= '0;
            drain_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (wt_fire) row_idx <= row_last ? '0 : row_idx + RIW'(1);
            drain_cnt <= (state == DRAIN) ? drain_cnt + CNTW'(1) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) w[r][c] <= '0;
        end else if (wt_fire) begin
            for (int c = 0; c < COLS; c++) w[row_idx][c] <= wt_row[c*DATAWIDTH +: DATAWIDTH];
        end
    end

    // p0: input skew, row r and seed column c delayed by r / c cycles
    for (genvar r = 0; r < ROWS; r++) begin : g_askew
        logic signed [DATAWIDTH-1:0] sk_p0 [r+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= r; k++) sk_p0[k] <= '0;
            end else begin
                sk_p0[0] <= a_fire ? a_vec[r*DATAWIDTH +: DATAWIDTH] : '0;
                for (int k = 1; k <= r; k++) sk_p0[k] <= sk_p0[k-1];
            end
        end
        assign a_edge[r] = sk_p0[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_sskew
        logic signed [DATAWIDTH_output-1:0] sk_p0 [c+1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= c; k++) sk_p0[k] <= '0;
            end else begin
                sk_p0[0] <= (a_fire && acc_en) ? psum_in[c*DATAWIDTH_output +: DATAWIDTH_output] : '0;
                for (int k = 1; k <= c; k++) sk_p0[k] <= sk_p0[k-1];
            end
        end
        assign seed_edge[c] = sk_p0[c];
    end

    // p1: PE array, activations move right and partial sums move down each cycle
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            if (c == 0) begin : g_ain
                assign a_left[r][c] = a_edge[r];
            end else begin : g_apass
                assign a_left[r][c] = a_pe[r][c-1];
            end
            if (r == 0) begin : g_pin
                assign ps_up[r][c] = seed_edge[c];
            end else begin : g_ppass
                assign ps_up[r][c] = ps_pe[r-1][c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    a_pe[r][c]  <= '0;
                    ps_pe[r][c] <= '0;
                end
        end else begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    a_pe[r][c]  <= a_left[r][c];
                    ps_pe[r][c] <= mac(ps_up[r][c], a_left[r][c], w[r][c]);
                end
        end
    end

    // p2: deskew, column c waits COLS-1-c cycles so a result lines up in one cycle
    for (genvar c = 0; c < COLS; c++) begin : g_dsk
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign dsk_out[c] = ps_pe[ROWS-1][c];
        end else begin : g_delay
            logic signed [DATAWIDTH_output-1:0] dq_p2 [D];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) dq_p2[k] <= '0;
                end else begin
                    dq_p2[0] <= ps_pe[ROWS-1][c];
                    for (int k = 1; k < D; k++) dq_p2[k] <= dq_p2[k-1];
                end
            end
            assign dsk_out[c] = dq_p2[D-1];
        end
    end

    // p3: output register, loaded only when a real result arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p   <= '0;
            c_valid <= 1'b0;
            c_vec   <= '0;
        end else begin
            vld_p   <= {vld_p[LAT-2:0], a_fire};
            c_valid <= vld_p[LAT-1];
            if (vld_p[LAT-1])
                for (int c = 0; c < COLS; c++)
                    c_vec[c*DATAWIDTH_output +: DATAWIDTH_output] <= dsk_out[c];
        end
    end

endmodule

// File: tb/tb_systolic_ws_tile.sv
// Directed bench for a 4x4 weight-stationary tile: loads weights, streams vectors and
// compares results, timing and control outputs against hand-computed values.
module tb_systolic_ws_tile;

    logic          clk;
    logic          rst_n;
    logic          wt_valid;
    logic          wt_ready;
    logic [31:0]   wt_row;
    logic          a_valid;
    logic          a_ready;
    logic          a_last;
    logic [31:0]   a_vec;
    logic          acc_en;
    logic [127:0]  psum_in;
    logic          c_valid;
    logic [127:0]  c_vec;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    logic signed [7:0]  wmat [4][4];
    logic signed [7:0]  avec [3][4];
    logic signed [31:0] seed [4];
    int                 expv [3][4];

    systolic_ws_tile #(
        .ROWS(4), .COLS(4), .DATAWIDTH(8), .DATAWIDTH_output(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_row(wt_row),
        .a_valid(a_valid), .a_ready(a_ready), .a_last(a_last), .a_vec(a_vec),
        .acc_en(acc_en), .psum_in(psum_in),
        .c_valid(c_valid), .c_vec(c_vec), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int cv(input int c);
        return int'($signed(c_vec[c*32 +: 32]));
    endfunction

    task automatic load_w();
        for (int r = 0; r < 4; r++) begin
            wt_valid = 1'b1;
            for (int c = 0; c < 4; c++) wt_row[c*8 +: 8] = wmat[r][c];
            chk("wt_ready_load", int'(wt_ready), 1);
            tick();
        end
        wt_valid = 1'b0;
        chk("a_ready_compute", int'(a_ready), 1);
        chk("wt_ready_compute", int'(wt_ready), 0);
        chk("busy_compute", int'(busy), 1);
    endtask

    task automatic run_tile(input int n, input logic acc);
        int p;
        for (int i = 0; i < n; i++) begin
            a_valid = 1'b1;
            a_last  = (i == n - 1);
            acc_en  = acc;
            for (int r = 0; r < 4; r++) a_vec[r*8 +: 8] = avec[i][r];
            for (int c = 0; c < 4; c++) psum_in[c*32 +: 32] = seed[c];
            chk("a_ready", int'(a_ready), 1);
            tick();
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
        acc_en  = 1'b0;
        p = n - 1;
        while (p < 8 + n) begin
            tick();
            p++;
            if (p >= 8 && p < 8 + n) begin
                chk("c_valid_on", int'(c_valid), 1);
                for (int c = 0; c < 4; c++) chk("c_vec", cv(c), expv[p-8][c]);
            end else begin
                chk("c_valid_off", int'(c_valid), 0);
            end
        end
        chk("busy_idle", int'(busy), 0);
        chk("wt_ready_idle", int'(wt_ready), 1);
        for (int c = 0; c < 4; c++) chk("c_vec_hold", cv(c), expv[n-1][c]);
    endtask

    initial begin
        rst_n    = 1'b0;
        wt_valid = 1'b0;
        wt_row   = '0;
        a_valid  = 1'b0;
        a_last   = 1'b0;
        a_vec    = '0;
        acc_en   = 1'b0;
        psum_in  = '0;

        // reset state
        #12;
        chk("rst_wt_ready", int'(wt_ready), 0);
        chk("rst_a_ready", int'(a_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_c_valid", int'(c_valid), 0);
        chk("rst_c_vec0", cv(0), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rel_wt_ready", int'(wt_ready), 1);

        // activations ignored while idle
        a_valid = 1'b1;
        a_vec   = 32'h01010101;
        tick();
        chk("idle_a_ready", int'(a_ready), 0);
        chk("idle_busy", int'(busy), 0);
        a_valid = 1'b0;

        // identity weights, a=[1,2,3,4], seed present but acc_en=0
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) wmat[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        load_w();
        avec[0] = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        seed    = '{32'sd7, 32'sd7, 32'sd7, 32'sd7};
        expv[0] = '{1, 2, 3, 4};
        run_tile(1, 1'b0);

        // extreme operands: 4 * 127 * -128
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) wmat[r][c] = 8'sd127;
        load_w();
        avec[0] = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
        expv[0] = '{-65024, -65024, -65024, -65024};
        run_tile(1, 1'b0);

        // three back-to-back vectors, all-ones weights
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) wmat[r][c] = 8'sd1;
        load_w();
        avec[0] = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        avec[1] = '{8'sd2, 8'sd2, 8'sd2, 8'sd2};
        avec[2] = '{8'sd3, 8'sd3, 8'sd3, 8'sd3};
        expv[0] = '{4, 4, 4, 4};
        expv[1] = '{8, 8, 8, 8};
        expv[2] = '{12, 12, 12, 12};
        run_tile(3, 1'b0);

        // identity weights, weight writes attempted during COMPUTE, then seeded accumulate
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) wmat[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        load_w();
        wt_valid = 1'b1;
        wt_row   = 32'h05050505;
        #1;
        chk("compute_wt_ready", int'(wt_ready), 0);
        tick();
        tick();
        chk("compute_still", int'(a_ready), 1);
        wt_valid = 1'b0;
        avec[0] = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
        seed    = '{32'sd100, 32'sd200, 32'sd300, 32'sd400};
        expv[0] = '{101, 201, 301, 401};
        run_tile(1, 1'b1);

        // reset pulsed mid-drain discards the in-flight result and clears weights
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) wmat[r][c] = 8'sd1;
        load_w();
        a_valid = 1'b1;
        a_last  = 1'b1;
        a_vec   = 32'h01010101;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_wt_ready", int'(wt_ready), 0);
        chk("midrst_a_ready", int'(a_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 12; k++) begin
            chk("post_rst_c_valid", int'(c_valid), 0);
            tick();
        end
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_wt_ready", int'(wt_ready), 1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) chk("w_cleared", int'(dut.w[r][c]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_ws_tile.md
SYSTOLIC_WS_TILE -- requirements
Module: systolic_ws_tile

Interface
REQ-001 SHALL have parameter ROWS, default 32: array rows, i.e. the reduction depth (K).
REQ-002 SHALL have parameter COLS, default 32: array columns, i.e. the output width (N).
REQ-003 SHALL have parameter DATAWIDTH, default 8: signed operand width.
REQ-004 SHALL have parameter DATAWIDTH_output, default 32: signed accumulator and result width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port wt_valid, input, 1 bit: a weight row is offered.
REQ-008 SHALL have port wt_ready, output, 1 bit: a weight row can be accepted.
REQ-009 SHALL have port wt_row, input, DATAWIDTH x COLS: the weight row; element c targets PE(row_idx, c).
REQ-010 SHALL have port a_valid, input, 1 bit: an activation vector is offered.
REQ-011 SHALL have port a_ready, output, 1 bit: an activation vector can be accepted.
REQ-012 SHALL have port a_last, input, 1 bit: qualified by the a handshake; marks the final vector of the tile.
REQ-013 SHALL have port a_vec, input, DATAWIDTH x ROWS: the activation vector; element r feeds array row r.
REQ-014 SHALL have port acc_en, input, 1 bit: sampled with the a handshake; selects adding psum_in.
REQ-015 SHALL have port psum_in, input, DATAWIDTH_output x COLS: the partial-sum seed, sampled with the a handshake.
REQ-016 SHALL have port c_valid, output, 1 bit: c_vec holds a complete result; there is no backpressure on it.
REQ-017 SHALL have port c_vec, output, DATAWIDTH_output x COLS: the deskewed result vector.
REQ-018 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-019 SHALL implement a four-state FSM.
- IDLE to LOAD on the first wt handshake.
- LOAD to COMPUTE on the ROWS-th wt handshake.
- COMPUTE to DRAIN on an a handshake that has a_last=1.
- DRAIN to IDLE once the last in-flight result has produced c_valid.
REQ-020 SHALL assert wt_ready in IDLE and LOAD only, and a_ready in COMPUTE only.
REQ-021 SHALL track row_idx (0..ROWS-1) with a counter.
- The counter increments on each wt handshake.
- On a handshake, wt_row is written to stationary register W[row_idx][0..COLS-1].
- The counter clears on entering COMPUTE.
REQ-022 SHALL ignore wt_valid outside IDLE/LOAD and a_valid outside COMPUTE, with no state change.
REQ-023 SHALL skew inputs so that a_vec[r] enters PE(r,0) r cycles later than a_vec[0].
REQ-024 SHALL pass activations right and partial sums down through registers in each PE; PE(r,c) outputs psum_down = psum_up + a*W[r][c].
REQ-025 SHALL seed column c at row 0 with psum_in[c] when acc_en=1, else 0; the seed is skewed with its column.
REQ-026 SHALL deskew outputs so that all COLS elements of one result appear in the same cycle.
REQ-027 SHALL assert c_valid, for one cycle per accepted vector, exactly ROWS+COLS cycles after the accepting edge; acceptance order is preserved.
REQ-028 SHALL compute c_vec[c] = seed[c] + sum over r of a_vec[r]*W[r][c].
- Multiplication is signed, with a 2*DATAWIDTH product sign-extended.
- The sum wraps modulo 2^DATAWIDTH_output, two's complement, with no saturation.
REQ-029 SHALL accept one vector per cycle in COMPUTE (full throughput), with no bubbles required between vectors.
REQ-030 SHALL accept a_last on the first vector of the tile; DRAIN then lasts until that single result emits.
REQ-031 SHALL run the DRAIN counter for ROWS+COLS cycles from the a_last edge; IDLE is entered on the cycle after the final c_valid.
REQ-032 SHALL retain weights across IDLE, so a new tile may reuse them.
- A new LOAD overwrites all ROWS rows.
- Reuse requires a new wt sequence; there is no direct IDLE-to-COMPUTE path.
REQ-033 SHALL hold c_vec at its last value when c_valid=0.

Reset
REQ-034 SHALL, on rst_n low (asynchronous), force the state to IDLE and clear row_idx, W, the skew, PE and deskew registers, the DRAIN counter, c_vec and c_valid to 0.
REQ-035 SHALL, during reset, drive wt_ready=0, a_ready=0 and busy=0; after reset release wt_ready=1.
REQ-036 SHALL discard in-flight results when reset asserts mid-operation; no c_valid follows release.

Verification (ROWS=COLS=4, DATAWIDTH=8, DATAWIDTH_output=32)
REQ-037 Identity weights, then a_vec=[1,2,3,4] with a_last and acc_en=0 -> c_vec=[1,2,3,4] with c_valid exactly 8 cycles after acceptance; then state returns to IDLE.
REQ-038 All weights 127 and a_vec all -128 -> every c_vec element = -65024.
REQ-039 Three back-to-back vectors [1,1,1,1], [2,2,2,2], [3,3,3,3] with W all 1 -> c_valid on 3 consecutive cycles with elements 4, 8, 12.
REQ-040 acc_en=1 with psum_in=[100,200,300,400], identity W and a=[1,1,1,1] -> c_vec=[101,201,301,401].
REQ-041 rst_n pulsed low 3 cycles after a_last -> no c_valid afterwards, busy=0, wt_ready=1, and W reads as 0 (zero weights give result = seed).
REQ-042 wt_valid=1 with new data during COMPUTE -> wt_ready=0, weights unchanged, results match the original W.
